bcd_pulse_gen: RTL and testbench

BCD_PULSE_GEN -- requirements
Module: bcd_pulse_gen

---
 rtl/bcd_pulse_pkg.sv | 12 +
 rtl/bcd_down_digit.sv | 29 ++
 rtl/bcd_pulse_gen.sv | 121 ++++++++++++
 tb/tb_bcd_pulse_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bcd_pulse_pkg.sv
// Shared FSM state encoding and BCD limits for the BCD pulse-train generator.
package bcd_pulse_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PULSE = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counter digit: loadable, wraps 0->9 on a borrowed decrement.
module bcd_down_digit
  import bcd_pulse_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec_en,
  input  logic       i_borrow_in,
  output logic [3:0] o_digit,
  output logic       o_zero,
  output logic       o_borrow_out
);

  logic [3:0] r_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_digit <= 4'd0;
    else if (i_load)                  r_digit <= i_load_val;
    else if (i_dec_en && i_borrow_in) r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
  end

  assign o_digit      = r_digit;
  assign o_zero       = (r_digit == 4'd0);
  // Borrow ripples to the next digit only when this digit is actually wrapping.
  assign o_borrow_out = i_dec_en & i_borrow_in & o_zero;

endmodule

// File: rtl/bcd_pulse_gen.sv
// Emits tens*10+ones one-cycle pulses spaced gap+1 cycles apart, then a done strobe.
module bcd_pulse_gen
  import bcd_pulse_pkg::*;
#(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       bcd_tens,
  input  logic [3:0]       bcd_ones,
  input  logic [GAP_W-1:0] gap,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gcnt;
  logic             r_pulse, r_busy, r_done, r_err;

  logic       w_valid, w_nonzero, w_load, w_dec, w_last;
  logic [3:0] w_ones, w_tens;
  logic       w_ones_zero, w_tens_zero, w_ones_borrow, w_tens_borrow;
  logic       w_unused;

  assign w_valid   = (bcd_tens <= BCD_MAX) && (bcd_ones <= BCD_MAX);
  assign w_nonzero = |{bcd_tens, bcd_ones};
  assign w_load    = (r_state == ST_IDLE) && start && w_valid && w_nonzero;
  // Counters hold the count including the pulse currently on the output.
  assign w_dec     = (r_state == ST_PULSE);
  assign w_last    = w_tens_zero && (w_ones == 4'd1);
  assign w_unused  = ^{w_ones_zero, w_tens_borrow, w_tens};

  bcd_down_digit u_ones (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_val   (bcd_ones),
    .i_dec_en     (w_dec),
    .i_borrow_in  (1'b1),
    .o_digit      (w_ones),
    .o_zero       (w_ones_zero),
    .o_borrow_out (w_ones_borrow)
  );

  bcd_down_digit u_tens (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_val   (bcd_tens),
    .i_dec_en     (w_dec),
    .i_borrow_in  (w_ones_borrow),
    .o_digit      (w_tens),
    .o_zero       (w_tens_zero),
    .o_borrow_out (w_tens_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      r_gcnt  <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (!w_valid) begin
              r_err <= 1'b1;
            end else if (!w_nonzero) begin
              r_done <= 1'b1;
            end else begin
              r_gap   <= gap;
              r_pulse <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_PULSE;
            end
          end
        end
        ST_PULSE: begin
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_gap == '0) begin
            r_pulse <= 1'b1;
          end else begin
            r_gcnt  <= r_gap - GAP_ONE;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gcnt == '0) begin
            r_pulse <= 1'b1;
            r_state <= ST_PULSE;
          end else begin
            r_gcnt <= r_gcnt - GAP_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pulse = r_pulse;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_bcd_pulse_gen.sv
// Scoreboard bench: each accepted start pushes the expected per-cycle output trace.
module tb_bcd_pulse_gen;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] bcd_tens, bcd_ones;
  logic [7:0] gap;
  logic       pulse, busy, done, err;

  // Expected {pulse,busy,done,err} for one cycle
  localparam logic [3:0] E_P = 4'b1100;
  localparam logic [3:0] E_B = 4'b0100;
  localparam logic [3:0] E_D = 4'b0010;
  localparam logic [3:0] E_E = 4'b0001;

  logic [3:0] exp_q[$];
  logic [3:0] cur;
  int         n_chk  = 0;
  int         n_fail = 0;

  bcd_pulse_gen #(.GAP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .gap      (gap),
    .pulse    (pulse),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s got pbde=%b want pbde=%b at t=%0t", tag, act, expv, $time);
    end
  endtask

  // Compare the cycle about to end against the scoreboard head.
  task automatic tick(input string tag);
    @(negedge clk);
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else                  cur = 4'b0000;
    chk(tag, {pulse, busy, done, err}, cur);
  endtask

  task automatic drive(input logic r, input logic s, input logic [3:0] t,
                       input logic [3:0] o, input logic [7:0] g);
    int n;
    rst = r; start = s; bcd_tens = t; bcd_ones = o; gap = g;
    if (r) begin
      #1;
      chk("rst_async", {pulse, busy, done, err}, 4'b0000);
      exp_q.delete();
      cur = 4'b0000;
    end else if (s && !cur[2]) begin
      if (t > 4'd9 || o > 4'd9) begin
        exp_q.push_back(E_E);
      end else begin
        n = int'(t) * 10 + int'(o);
        for (int i = 0; i < n; i++) begin
          exp_q.push_back(E_P);
          if (i < n - 1)
            for (int j = 0; j < int'(g); j++) exp_q.push_back(E_B);
        end
        exp_q.push_back(E_D);
      end
    end
  endtask

  task automatic idle_drive();
    drive(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          8'($urandom_range(0, 255)));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      tick(tag);
      idle_drive();
    end
    if (exp_q.size() != 0) chk({tag, "_timeout"}, 4'b1111, 4'b0000);
    tick({tag, "_idle"});
    idle_drive();
  endtask

  initial begin
    int np;
    cur = 4'b0000;
    rst = 1'b1; start = 1'b0; bcd_tens = 4'd0; bcd_ones = 4'd0; gap = 8'd0;
    tick("reset0"); drive(1'b1, 1'b0, 4'd0, 4'd0, 8'd0);
    tick("reset1"); drive(1'b1, 1'b1, 4'd1, 4'd1, 8'd0);

    // First edge after release accepts: 3 pulses back-to-back
    tick("rel");    drive(1'b0, 1'b1, 4'd0, 4'd3, 8'd0);
    drain("n3_g0");

    // 12 pulses, gap 2: ones wraps and borrows from tens
    tick("pre12");  drive(1'b0, 1'b1, 4'd1, 4'd2, 8'd2);
    drain("n12_g2");

    tick("pre0");   drive(1'b0, 1'b1, 4'd0, 4'd0, 8'd5);
    drain("n0");
    tick("pre_e1"); drive(1'b0, 1'b1, 4'd0, 4'd10, 8'd0);
    drain("err_ones");
    tick("pre_e2"); drive(1'b0, 1'b1, 4'd12, 4'd3, 8'd0);
    drain("err_tens");

    // Start held through the train with 9/9 is ignored; restart in done cycle
    tick("pre4");   drive(1'b0, 1'b1, 4'd0, 4'd4, 8'd1);
    for (int i = 0; i < 60; i++) begin
      tick("ign");
      if (cur[1]) begin
        drive(1'b0, 1'b1, 4'd0, 4'd2, 8'd0);
        break;
      end
      drive(1'b0, 1'b1, 4'd9, 4'd9, 8'd0);
    end
    tick("redo0");  idle_drive();
    drain("redo");

    // Reset one cycle after the 5th pulse of a 9-pulse train
    tick("pre9");   drive(1'b0, 1'b1, 4'd0, 4'd9, 8'd1);
    np = 0;
    for (int i = 0; i < 40 && np < 5; i++) begin
      tick("mid9");
      if (cur[3]) np++;
      idle_drive();
    end
    tick("mid9b");  drive(1'b1, 1'b0, 4'd0, 4'd0, 8'd0);
    tick("rst_hold"); drive(1'b1, 1'b0, 4'd0, 4'd0, 8'd0);
    tick("rst_rel"); drive(1'b0, 1'b1, 4'd0, 4'd9, 8'd0);
    drain("post_rst");

    // Full-scale 99 pulses back-to-back
    tick("pre99");  drive(1'b0, 1'b1, 4'd9, 4'd9, 8'd0);
    drain("n99");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
